// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP datapath stages.
// Number model: truncation, denormals flushed to zero, overflow saturates to infinity.
package fp_pkg;

  localparam int          FP_EXP_W    = 8;
  localparam int          FP_MANT_W   = 23;
  localparam int          FP_BIAS     = 127;
  localparam logic [7:0]  FP_EXP_INF  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } acc_state_e;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W:0]   mant24;
    logic                 is_zero;
  } fp_unpacked_t;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, FP_EXP_INF, {FP_MANT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single word into sign/exponent/24-bit mantissa.
// exp==0 is treated as zero, so denormal inputs vanish here.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]  word_i,
  output fp_unpacked_t op_o
);

  logic zero;

  always_comb begin
    zero           = (word_i[30:23] == '0);
    op_o.sign      = word_i[31];
    op_o.exp       = word_i[30:23];
    op_o.is_zero   = zero;
    op_o.mant24    = zero ? 24'h0 : {1'b1, word_i[22:0]};
  end

endmodule

// File: rtl/fp_product_accumulator.sv
// Multi-cycle FP accumulator fed by the multiplier: align one bit per cycle,
// add, then normalise one bit per cycle into the 32-bit running sum.
module fp_product_accumulator
  import fp_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_ALIGN = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_ovf,
  output logic [31:0]      acc_out,
  output logic             acc_valid,
  output logic [CNT_W-1:0] term_cnt,
  output logic             acc_inf
);

  localparam logic [7:0] ALIGN_LIM = 8'(MAX_ALIGN);

  acc_state_e       state_q;
  logic [31:0]      in_q, acc_q;
  logic             ovf_q, inf_q, vld_q, first_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bsign_q, ssign_q;
  logic [7:0]       bexp_q, sh_q;
  logic [25:0]      bm_q, sm_q;

  fp_unpacked_t acc_op, in_op;

  fp_unpack u_unpack_acc (.word_i(acc_q), .op_o(acc_op));
  fp_unpack u_unpack_in  (.word_i(in_q),  .op_o(in_op));

  // Operand ordering for the align step: "big" is the larger exponent.
  logic       in_big;
  logic [7:0] diff;

  always_comb begin
    in_big = (in_op.exp > acc_op.exp);
    diff   = in_big ? (in_op.exp - acc_op.exp) : (acc_op.exp - in_op.exp);
  end

  logic        same_sign, big_ge, add_sign;
  logic [25:0] add_m;

  always_comb begin
    same_sign = (bsign_q == ssign_q);
    big_ge    = (bm_q >= sm_q);
    if (same_sign)   add_m = bm_q + sm_q;
    else if (big_ge) add_m = bm_q - sm_q;
    else             add_m = sm_q - bm_q;
    add_sign  = (same_sign || big_ge) ? bsign_q : ssign_q;
  end

  // One normalisation step; nrm_ok means this step leaves the result in range.
  logic [25:0] nrm_m;
  logic [7:0]  nrm_e;
  logic        nrm_inf, nrm_flush, nrm_ok;

  always_comb begin
    nrm_m     = bm_q;
    nrm_e     = bexp_q;
    nrm_inf   = 1'b0;
    nrm_flush = 1'b0;
    if (bm_q[24]) begin
      nrm_m   = bm_q >> 1;
      nrm_e   = bexp_q + 8'd1;
      nrm_inf = (nrm_e == FP_EXP_INF);
    end else if (!bm_q[23]) begin
      nrm_m     = bm_q << 1;
      nrm_e     = bexp_q - 8'd1;
      nrm_flush = (nrm_e == 8'd0);
    end
    nrm_ok = (nrm_m[25:23] == 3'b001);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      acc_q   <= FP_POS_ZERO;
      ovf_q   <= 1'b0;
      inf_q   <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      bsign_q <= 1'b0;
      ssign_q <= 1'b0;
      bexp_q  <= '0;
      sh_q    <= '0;
      bm_q    <= '0;
      sm_q    <= '0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      acc_q   <= FP_POS_ZERO;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      inf_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_q    <= in_data;
            ovf_q   <= in_ovf;
            first_q <= 1'b1;
            state_q <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (first_q) begin
            first_q <= 1'b0;
            if (inf_q) begin
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
            end else if (ovf_q || in_op.exp == FP_EXP_INF) begin
              acc_q   <= fp_inf(in_op.sign);
              inf_q   <= 1'b1;
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
            end else if (in_op.is_zero) begin
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
            end else if (acc_op.is_zero) begin
              acc_q   <= in_q;
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
            end else if (diff >= ALIGN_LIM) begin
              acc_q   <= in_big ? in_q : acc_q;
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
            end else begin
              // First shift happens here so ALIGN spans exactly max(1,d) cycles.
              bsign_q <= in_big ? in_op.sign : acc_op.sign;
              bexp_q  <= in_big ? in_op.exp  : acc_op.exp;
              bm_q    <= {2'b00, in_big ? in_op.mant24 : acc_op.mant24};
              ssign_q <= in_big ? acc_op.sign : in_op.sign;
              sm_q    <= {2'b00, in_big ? acc_op.mant24 : in_op.mant24} >> (diff != 8'd0);
              sh_q    <= diff;
              if (diff <= 8'd1) state_q <= ST_ADD;
            end
          end else begin
            sm_q <= sm_q >> 1;
            sh_q <= sh_q - 8'd1;
            if (sh_q == 8'd2) state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (add_m == '0) begin
            acc_q   <= FP_POS_ZERO;
            state_q <= ST_DONE;
            vld_q   <= 1'b1;
          end else begin
            bm_q    <= add_m;
            bsign_q <= add_sign;
            state_q <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (nrm_inf) begin
            acc_q   <= fp_inf(bsign_q);
            inf_q   <= 1'b1;
            state_q <= ST_DONE;
            vld_q   <= 1'b1;
          end else if (nrm_flush) begin
            acc_q   <= FP_POS_ZERO;
            state_q <= ST_DONE;
            vld_q   <= 1'b1;
          end else if (nrm_ok) begin
            acc_q   <= {bsign_q, nrm_e, nrm_m[22:0]};
            state_q <= ST_DONE;
            vld_q   <= 1'b1;
          end else begin
            bm_q   <= nrm_m;
            bexp_q <= nrm_e;
          end
        end
        ST_DONE: begin
          cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !clear;
  assign acc_out   = acc_q;
  assign acc_valid = vld_q;
  assign term_cnt  = cnt_q;
  assign acc_inf   = inf_q;

endmodule
